mdu_seq_ctrl: RTL and testbench
===============================

Name: mdu_seq_ctrl

Overview:
- Iterative unsigned multiply/divide sequencer for the 32-bit MIPS core (MULTU/DIVU), producing HI/LO.
- Owns no adder. It time-shares the existing combinational 32-bit ALU by driving that ALU's operand and control inputs and reading its result in the same cycle.
- Sits beside the execute stage. The pipeline control stalls on busy and reads HI/LO after done.

Parameters:
- WIDTH, 32, operand width; only 32 is supported.
- ALU_ADD, 4'b0010, ALU control code for add.
- ALU_SUB, 4'b0110, ALU control code for subtract.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch operation; accepted only when ready=1.
- op_div  input  1  sampled with start: 0 = MULTU, 1 = DIVU.
- opa  input  32  multiplier / dividend, sampled with start.
- opb  input  32  multiplicand / divisor, sampled with start.
- ready  output  1  1 in IDLE and DONE (start accepted).
- busy  output  1  1 in MUL and DIV.
- done  output  1  one-cycle pulse; HI/LO valid.
- hi  output  32  product[63:32] / remainder.
- lo  output  32  product[31:0] / quotient.
- alu_in1  output  32  to shared ALU in1.
- alu_in2  output  32  to shared ALU in2.
- alu_ctrl  output  4  to shared ALU aluCtrl.
- alu_result  input  32  from shared ALU result; combinational, same cycle.

Behaviour:
- Reset (synchronous, active-high; it has priority everywhere, including mid-operation):
  - State goes to IDLE.
  - hi = 0, lo = 0, done = 0, busy = 0, ready = 1.
  - Iteration counter = 0. Latched operand register = 0.
  - Any operation in flight is abandoned; no done pulse follows.
- States: IDLE, MUL, DIV, DONE.
- Start, from IDLE or DONE with start=1:
  - op_div=0: hi <= 0, lo <= opa, latch opb as multiplicand, counter <= 0, go to MUL.
  - op_div=1 and opb != 0: hi <= 0, lo <= opa, latch opb as divisor, counter <= 0, go to DIV.
  - op_div=1 and opb == 0: hi <= opa, lo <= 32'hFFFFFFFF, go directly to DONE (done pulse next cycle, no iterations).
- start is ignored while busy=1.
- MUL, each cycle:
  - Drive alu_in1 = hi, alu_in2 = multiplicand, alu_ctrl = ALU_ADD.
  - If lo[0]=1: carry = (alu_result < hi) unsigned; {hi,lo} <= {carry, alu_result, lo} >> 1.
  - If lo[0]=0: {hi,lo} <= {1'b0, hi, lo} >> 1.
- DIV, each cycle:
  - Form r = {hi[30:0], lo[31]} and m = hi[31].
  - Drive alu_in1 = r, alu_in2 = divisor, alu_ctrl = ALU_SUB.
  - If m=1 or r >= divisor (unsigned): hi <= alu_result, lo <= {lo[30:0], 1}.
  - Otherwise: hi <= r, lo <= {lo[30:0], 0}.
- Iteration count:
  - counter increments once per MUL/DIV cycle.
  - On the cycle counter == 31, the 32nd iteration commits and the state moves to DONE.
- DONE:
  - done = 1 for exactly this cycle; hi/lo are final.
  - Next state is IDLE, unless start=1 (then new launch as above; done still pulses this cycle).
- Latency: start accepted at edge N; busy=1 for 32 cycles; done=1 in the cycle after edge N+32.
- Hold: hi/lo hold their final values in IDLE until the next accepted start or reset.
- ALU drive when not in MUL/DIV: alu_in1 = 0, alu_in2 = 0, alu_ctrl = ALU_ADD (ALU result ignored).
- Outputs busy, ready and done are decoded from the registered state only; no combinational path from start.
- Arithmetic:
  - Results are unsigned and mod 2^32 per half.
  - Multiply carry is recovered from the 32-bit wraparound compare.
  - Divide uses restoring division; the m=1 case relies on the ALU subtract wrapping modulo 2^32.

Test Plan:
- MULTU 6 x 7 -> done exactly 33 cycles after start edge; hi=0x00000000, lo=0x0000002A; alu_ctrl=0010 throughout busy.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (exercises carry every add).
- DIVU 100 / 7 -> lo=14, hi=2. DIVU 0xFFFFFFFF / 1 -> lo=0xFFFFFFFF, hi=0. DIVU 0x80000000 / 0xFFFFFFFF -> lo=0, hi=0x80000000. All with alu_ctrl=0110 throughout busy.
- DIVU 5 / 0 -> done on the cycle after the start edge; hi=5, lo=0xFFFFFFFF; busy never asserted.
- start pulsed with different operands at busy cycle 10 -> ignored; original result delivered on schedule. start asserted during DONE -> done still pulses, new operation begins, busy next cycle.
- reset asserted at busy cycle 20 -> next cycle IDLE, hi=lo=0, done=0, ready=1; no later done pulse. A fresh MULTU 3 x 5 then yields lo=15.

Source files
------------

// File: rtl/mdu_seq_ctrl.sv
// mdu_seq_ctrl: iterative MULTU/DIVU sequencer producing HI/LO over 32 cycles.
// It has no adder of its own; it borrows the execute-stage ALU while busy.
module mdu_seq_ctrl #(
    parameter int         WIDTH   = 32,
    parameter logic [3:0] ALU_ADD = 4'b0010,
    parameter logic [3:0] ALU_SUB = 4'b0110
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] hi_q, lo_q, opb_q, hi_d, lo_d, rem;
    logic [4:0]       cnt_q;
    logic             carry, take, is_mul, is_div;
    always_comb begin
        is_mul   = state_q == MUL;
        is_div   = state_q == DIV;
        rem      = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        // The add wrapped iff the sum came out below the running high half.
        carry    = alu_result < hi_q;
        take     = hi_q[WIDTH-1] || rem >= opb_q;
        alu_in1  = is_mul ? hi_q : is_div ? rem : '0;
        alu_in2  = (is_mul || is_div) ? opb_q : '0;
        alu_ctrl = is_div ? ALU_SUB : ALU_ADD;
        hi_d     = is_mul ? (lo_q[0] ? {carry, alu_result[WIDTH-1:1]} : {1'b0, hi_q[WIDTH-1:1]})
                 : is_div ? (take ? alu_result : rem) : hi_q;
        lo_d     = is_mul ? {(lo_q[0] ? alu_result[0] : hi_q[0]), lo_q[WIDTH-1:1]}
                 : is_div ? {lo_q[WIDTH-2:0], take} : lo_q;
        ready    = state_q == IDLE || state_q == DONE;
        busy     = is_mul || is_div;
        done     = state_q == DONE;
        hi       = hi_q;
        lo       = lo_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                MUL, DIV: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= DONE;
                end
                default: begin
                    if (start) begin
                        cnt_q <= '0;
                        opb_q <= opb;
                        // Divide by zero skips iteration: remainder = dividend, quotient = all ones.
                        if (op_div && opb == '0) begin
                            hi_q    <= opa;
                            lo_q    <= '1;
                            state_q <= DONE;
                        end else begin
                            hi_q    <= '0;
                            lo_q    <= opa;
                            state_q <= op_div ? DIV : MUL;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// tb_mdu_seq_ctrl: randomized and directed checks of mdu_seq_ctrl against plain arithmetic.
module tb_mdu_seq_ctrl;
    logic        clk, reset, start, op_div, ready, busy, done;
    logic [31:0] opa, opb, hi, lo, alu_in1, alu_in2, alu_result;
    logic [3:0]  alu_ctrl;
    int          n_checks = 0;
    int          n_fail   = 0;

    mdu_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op_div(op_div), .opa(opa), .opb(opb),
        .ready(ready), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .alu_result(alu_result)
    );

    // Shared execute-stage ALU
    assign alu_result = alu_ctrl == 4'b0010 ? alu_in1 + alu_in2
                      : alu_ctrl == 4'b0110 ? alu_in1 - alu_in2 : 32'h0;

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_op(input logic d, input logic [31:0] a, input logic [31:0] b);
        if (!d) return {32'h0, a} * {32'h0, b};
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
    endfunction

    task automatic launch(input logic d, input logic [31:0] a, input logic [31:0] b);
        start = 1; op_div = d; opa = a; opb = b;
        @(posedge clk);
        #1 start = 0; opa = $urandom; opb = $urandom;
    endtask

    // Counts negedges after the start edge until done; n = -1 if done never shows within 40.
    task automatic wait_done(input logic [3:0] ctrl, input int inj, output int n,
                             output int busy_n, output bit ctrl_bad);
        n = -1; busy_n = 0; ctrl_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (inj > 0 && k == inj + 1) start = 0;
            if (inj > 0 && k == inj) begin
                start = 1; op_div = 1'($urandom_range(0, 1)); opa = $urandom; opb = $urandom | 32'h1;
            end
            if (busy) begin
                busy_n++;
                if (alu_ctrl !== ctrl) ctrl_bad = 1;
            end
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1; start = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        n_checks++;
        if ({ready, busy, done} !== 3'b100) begin
            n_fail++; $display("FAIL reset_flags got %b want 100", {ready, busy, done});
        end
        n_checks++;
        if ({hi, lo} !== 64'h0) begin
            n_fail++; $display("FAIL reset_hilo got %h want 0", {hi, lo});
        end
        n_checks++;
        if ({alu_in1, alu_in2, alu_ctrl} !== {64'h0, 4'b0010}) begin
            n_fail++; $display("FAIL reset_alu got %h %h %b want 0 0 0010", alu_in1, alu_in2, alu_ctrl);
        end
    endtask

    task automatic test_arith(input logic d);
        logic [31:0] a, b;
        logic [63:0] exp;
        int n, bn;
        bit bad;
        for (int i = 0; i < 10; i++) begin
            a = $urandom; b = $urandom;
            if (!d) begin
                if (i == 0) begin a = 6; b = 7; end
                if (i == 1) begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
                if (i == 2) a = 0;
                if (i == 3) begin a = 1; b = 32'hFFFFFFFF; end
            end else begin
                if (i == 0) begin a = 100; b = 7; end
                if (i == 1) begin a = 32'hFFFFFFFF; b = 1; end
                if (i == 2) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                if (i == 3) b = $urandom_range(1, 15);
                if (i == 4) begin a = 5; b = 9; end
                if (b == 0) b = 1;
            end
            exp = ref_op(d, a, b);
            launch(d, a, b);
            wait_done(d ? 4'b0110 : 4'b0010, 0, n, bn, bad);
            n_checks++;
            if (n !== 33) begin
                n_fail++; $display("FAIL %s_latency[%0d] got %0d want 33", d ? "div" : "mul", i, n);
            end
            n_checks++;
            if ({hi, lo} !== exp) begin
                n_fail++; $display("FAIL %s_result[%0d] %h,%h got %h want %h", d ? "div" : "mul", i, a, b, {hi, lo}, exp);
            end
            n_checks++;
            if (bad || bn !== 32) begin
                n_fail++; $display("FAIL %s_busy[%0d] ctrl_bad=%0d busy_cycles=%0d want 0/32", d ? "div" : "mul", i, bad, bn);
            end
            @(negedge clk);
            n_checks++;
            if ({done, ready, busy, hi, lo} !== {3'b010, exp}) begin
                n_fail++; $display("FAIL %s_hold[%0d] got %b %h want 010 %h", d ? "div" : "mul", i, {done, ready, busy}, {hi, lo}, exp);
            end
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] a;
        int n, bn;
        bit bad;
        for (int i = 0; i < 3; i++) begin
            a = i == 0 ? 32'd5 : $urandom;
            launch(1, a, 0);
            wait_done(4'b0110, 0, n, bn, bad);
            n_checks++;
            if (n !== 1 || bn !== 0) begin
                n_fail++; $display("FAIL div0_timing[%0d] got done_at=%0d busy_cycles=%0d want 1/0", i, n, bn);
            end
            n_checks++;
            if ({hi, lo} !== {a, 32'hFFFFFFFF}) begin
                n_fail++; $display("FAIL div0_result[%0d] got %h want %h", i, {hi, lo}, {a, 32'hFFFFFFFF});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start;
        logic [31:0] a, b;
        logic [63:0] exp;
        int n, bn;
        bit bad;
        a = $urandom; b = $urandom;
        exp = ref_op(0, a, b);
        launch(0, a, b);
        wait_done(4'b0010, 10, n, bn, bad);
        n_checks++;
        if (n !== 33 || bn !== 32) begin
            n_fail++; $display("FAIL ignore_timing got done_at=%0d busy_cycles=%0d want 33/32", n, bn);
        end
        n_checks++;
        if ({hi, lo} !== exp) begin
            n_fail++; $display("FAIL ignore_result got %h want %h", {hi, lo}, exp);
        end
        @(negedge clk);
        n_checks++;
        if ({done, ready, busy} !== 3'b010) begin
            n_fail++; $display("FAIL ignore_after got %b want 010", {done, ready, busy});
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b;
        logic [63:0] exp;
        int n, bn;
        bit bad;
        a = $urandom; b = $urandom;
        launch(0, a, b);
        wait_done(4'b0010, 0, n, bn, bad);
        n_checks++;
        if (n !== 33 || {hi, lo} !== ref_op(0, a, b)) begin
            n_fail++; $display("FAIL b2b_first got done_at=%0d %h want 33 %h", n, {hi, lo}, ref_op(0, a, b));
        end
        a = $urandom; b = $urandom_range(1, 1000);
        exp = ref_op(1, a, b);
        launch(1, a, b);
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_busy got busy,done=%b want 10", {busy, done});
        end
        wait_done(4'b0110, 0, n, bn, bad);
        n_checks++;
        if (n !== 32 || bn !== 31 || bad) begin
            n_fail++; $display("FAIL b2b_second_timing got done_at=%0d busy_cycles=%0d ctrl_bad=%0d want 32/31/0", n, bn, bad);
        end
        n_checks++;
        if ({hi, lo} !== exp) begin
            n_fail++; $display("FAIL b2b_second_result got %h want %h", {hi, lo}, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n, bn;
        bit bad;
        launch(0, $urandom, $urandom);
        repeat (20) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL rmid_busy got %b want 1", busy);
        end
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        n_checks++;
        if ({ready, busy, done, hi, lo} !== {3'b100, 64'h0}) begin
            n_fail++; $display("FAIL rmid_state got %b %h want 100 0", {ready, busy, done}, {hi, lo});
        end
        wait_done(4'b0010, 0, n, bn, bad);
        n_checks++;
        if (n !== -1 || bn !== 0) begin
            n_fail++; $display("FAIL rmid_no_done got done_at=%0d busy_cycles=%0d want -1/0", n, bn);
        end
        launch(0, 3, 5);
        wait_done(4'b0010, 0, n, bn, bad);
        n_checks++;
        if (n !== 33 || {hi, lo} !== 64'd15) begin
            n_fail++; $display("FAIL rmid_fresh got done_at=%0d %h want 33 15", n, {hi, lo});
        end
    endtask

    initial begin
        clk = 0; reset = 1; start = 0; op_div = 0; opa = 0; opb = 0;
        test_reset;
        test_arith(0);
        test_arith(1);
        test_div_zero;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
